// File: rtl/spi_master_ch.sv
// spi_master_ch: parametrised SPI master engine.
// Streams words of DATA_W bits over SPI for transfers of any length up to
// 2^LEN_W-1 bits, in any CPOL/CPHA mode, with a programmable SCK half-period
// of div+1 clk cycles and one of CS_N active-low chip selects.
// Optional feature macro: SPI_LOOPBACK_EN adds the lpbk input, which routes
// mosi back into the receive path and keeps every chip select deasserted.
module spi_master_ch #(
  parameter int  DATA_W = 8,
  parameter int  LEN_W  = 16,
  parameter int  DIV_W  = 8,
  parameter int  CS_N   = 2,
  localparam int CS_W   = (CS_N > 1) ? $clog2(CS_N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              work,
  input  logic              op,
  input  logic [LEN_W-1:0]  len,
  input  logic [DIV_W-1:0]  div,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_next,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              done,
  output logic              sck,
  output logic              mosi,
  output logic [CS_N-1:0]   cs_n,
`ifdef SPI_LOOPBACK_EN
  input  logic              lpbk,
`endif
  input  logic              miso
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]        state;
  logic [DIV_W-1:0]  hp_cnt;     // clk cycles elapsed in the current half-period
  logic [DIV_W-1:0]  div_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  bit_cnt;    // completed SCK periods
  logic [LEN_W-1:0]  samp_cnt;   // miso samples taken so far
  logic              ph;         // 0: next SCK toggle is the leading edge
  logic              op_q;
  logic              cpha_q;
  logic              cpol_q;
  logic [DATA_W-1:0] tx_sr;
  logic [IDX_W-1:0]  tx_idx;     // bit of the current word presented on mosi
  logic [DATA_W-1:0] rx_sr;
  logic [IDX_W-1:0]  rx_idx;     // bits gathered into the current word

  logic              accept;
  logic              hp_end;
  logic              sample_ev;
  logic              shift_ev;
  logic              last_edge;
  logic              rx_in;
  logic              lb_cs;      // forces every chip select high
  logic [DATA_W-1:0] rx_word;
  logic [DATA_W-1:0] tx_shift;

`ifdef SPI_LOOPBACK_EN
  logic lpbk_q;
  assign rx_in = lpbk_q ? mosi : miso;
  assign lb_cs = lpbk;
`else
  assign rx_in = miso;
  assign lb_cs = 1'b0;
`endif

  // Active-low decode; an out-of-range select leaves every line high.
  function automatic logic [CS_N-1:0] cs_decode(input logic [CS_W-1:0] sel);
    // NOTE: every bit is assigned on every call, so no storage is implied.
    logic [CS_N-1:0] r;
    for (int i = 0; i < CS_N; i++) r[i] = (sel != CS_W'(i));
    return r;
  endfunction

  assign accept    = (state == S_IDLE) && work && (len != '0);
  assign hp_end    = (hp_cnt == div_q);
  // CPHA=0 samples on the leading edge (ph=0), CPHA=1 on the trailing edge.
  assign sample_ev = (state == S_SHIFT) && hp_end && (ph == cpha_q);
  // The opposite edge shifts, except the very first CPHA=1 leading edge,
  // which only presents the MSB already set up in SETUP.
  assign shift_ev  = (state == S_SHIFT) && hp_end && (ph != cpha_q) && (samp_cnt != '0);
  assign last_edge = (state == S_SHIFT) && hp_end && ph && (bit_cnt == len_q - LEN_W'(1));
  assign rx_word   = (rx_sr << 1) | DATA_W'(rx_in);
  assign tx_shift  = tx_sr << 1;

  // Sequencer: state, half-period timing, SCK, chip selects, busy and done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: all state, shift registers included, is cleared by the async reset.
      state   <= S_IDLE;
      hp_cnt  <= '0;
      div_q   <= '0;
      len_q   <= '0;
      bit_cnt <= '0;
      ph      <= 1'b0;
      op_q    <= 1'b0;
      cpha_q  <= 1'b0;
      cpol_q  <= 1'b0;
      sck     <= 1'b0;
      cs_n    <= '1;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SPI_LOOPBACK_EN
      lpbk_q  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state != S_IDLE) hp_cnt <= hp_end ? '0 : hp_cnt + DIV_W'(1);
      case (state)
        S_IDLE: begin
          cpol_q <= cpol;
          sck    <= cpol;
          hp_cnt <= '0;
          if (accept) begin
            op_q    <= op;
            len_q   <= len;
            div_q   <= div;
            cpha_q  <= cpha;
            bit_cnt <= '0;
            ph      <= 1'b0;
            busy    <= 1'b1;
            cs_n    <= cs_decode(cs_sel) | {CS_N{lb_cs}};
            state   <= S_SETUP;
`ifdef SPI_LOOPBACK_EN
            lpbk_q  <= lpbk;
`endif
          end
        end
        S_SETUP: if (hp_end) state <= S_SHIFT;
        S_SHIFT: begin
          if (hp_end) begin
            sck <= ~sck;
            ph  <= ~ph;
            if (ph) bit_cnt <= bit_cnt + LEN_W'(1);
            if (last_edge) state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (hp_end) begin
            state <= S_GAP;
            cs_n  <= '1;
            if (div_q == '0) done <= 1'b1;
          end
        end
        S_GAP: begin
          // done must coincide with the final GAP cycle, i.e. the last busy cycle.
          if (!hp_end && (hp_cnt + DIV_W'(1) == div_q)) done <= 1'b1;
          if (hp_end) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Data path: transmit shifter with word refill, receive shifter with word delivery.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_sr    <= '0;
      tx_idx   <= '0;
      mosi     <= 1'b0;
      tx_next  <= 1'b0;
      samp_cnt <= '0;
      rx_sr    <= '0;
      rx_idx   <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      tx_next  <= 1'b0;
      rx_valid <= 1'b0;
      if (accept) begin
        tx_sr    <= tx_data;
        mosi     <= tx_data[DATA_W-1];
        tx_idx   <= '0;
        tx_next  <= 1'b1;
        samp_cnt <= '0;
        rx_sr    <= '0;
        rx_idx   <= '0;
      end
      if (sample_ev) begin
        samp_cnt <= samp_cnt + LEN_W'(1);
        if ((rx_idx == IDX_W'(DATA_W - 1)) || (samp_cnt == len_q - LEN_W'(1))) begin
          rx_sr  <= '0;
          rx_idx <= '0;
          if (!op_q) begin
            rx_data  <= rx_word;
            rx_valid <= 1'b1;
          end
        end else begin
          rx_sr  <= rx_word;
          rx_idx <= rx_idx + IDX_W'(1);
        end
      end
      if (shift_ev) begin
        if ((tx_idx == IDX_W'(DATA_W - 1)) && (samp_cnt != len_q)) begin
          tx_sr   <= tx_data;
          mosi    <= tx_data[DATA_W-1];
          tx_idx  <= '0;
          tx_next <= 1'b1;
        end else begin
          tx_sr  <= tx_shift;
          mosi   <= tx_shift[DATA_W-1];
          tx_idx <= tx_idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/spi_master_ch.md
# spi_master_ch

Parametrised SPI master engine generalising the single-mode, byte-wide SPI interface.
- Adds: configurable word width, programmable SCK divider, all four CPOL/CPHA modes, multiple chip selects, and a streaming word handshake for transfers of arbitrary bit length.
- Sits between the JTAG command decoder and external SPI flash devices; the decoder supplies length, operation and data words and collects received words.

## Interface
Parameters:
- DATA_W, 8, bits per data word (transmit and receive).
- LEN_W, 16, width of the bit-length field.
- DIV_W, 8, width of the SCK divider field.
- CS_N, 2, number of chip-select lines.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- work  in  1  start strobe; sampled only in IDLE.
- op  in  1  1 = write-only, 0 = full duplex (transmit and capture).
- len  in  LEN_W  transfer length in bits.
- div  in  DIV_W  SCK half-period equals div+1 clk cycles.
- cpol, cpha  in  1 each  SPI mode bits.
- cs_sel  in  $clog2(CS_N) (minimum 1)  target chip select.
- tx_data  in  DATA_W  word to transmit.
- tx_next  out  1  pulse: tx_data consumed; next word is expected.
- rx_data  out  DATA_W  received word.
- rx_valid  out  1  pulse: rx_data is valid.
- busy  out  1  transfer in progress.
- done  out  1  pulse at end of transfer.
- sck  out  1  SPI clock.
- mosi  out  1  SPI data out.
- cs_n  out  CS_N  active-low chip selects.
- miso  in  1  SPI data in.

## Operation
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
- **IDLE**
  - cpol_q loads cpol every cycle; sck = cpol_q.
  - work=1 with len≠0 latches op, len, div, cpha, cs_sel, cpol, and loads tx_data into the shift register.
  - tx_next pulses in the same cycle as that load; the FSM then moves to SETUP.
  - work=1 with len=0 is ignored (no busy, no done).
- **SETUP** (one half-period):
  - cs_n[cs_sel] is driven low.
  - mosi is driven with the first bit (MSB).
- **SHIFT** (2·len half-periods): sck toggles at the end of each half-period.
  - CPHA=0: sample miso on the leading edge; shift mosi on the trailing edge.
  - CPHA=1: shift mosi on the leading edge; sample on the trailing edge.
  - CPHA=1: the first leading edge presents the MSB, with no shift.
- **Word boundaries** (after DATA_W sampled bits, with more bits remaining):
  - tx_data is sampled into the shift register; tx_next pulses 1 cycle.
  - tx_data must be stable from the previous tx_next until that boundary.
- **Receive**
  - MSB first; new bits enter at the LSB.
  - op=0: rx_valid pulses 1 cycle after each DATA_W-th sample and after the final sample.
  - A final partial word is right-aligned, with upper bits zero.
  - op=1: rx_valid never asserts.
- **HOLD** (one half-period): sck is at cpol_q, and cs_n stays asserted.
- **GAP** (one half-period): all cs_n are high. On exit, done pulses 1 cycle, busy drops, and the FSM returns to IDLE.
- work is ignored while busy.
- cs_sel ≥ CS_N selects no line: the transfer runs with all cs_n high.

## Timing
- Reset values:
  - sck=0, mosi=0, cs_n=all 1.
  - busy=0, done=0, tx_next=0, rx_valid=0, rx_data=0.
  - FSM state = IDLE.
- Reset mid-transfer returns all outputs to their reset values immediately (asynchronous); no done pulse.
- Cycle accepting work = cycle 0. busy and the cs_n assertion appear at cycle 1.
- busy is high for exactly (2·len+3)·(div+1) cycles.
- done is coincident with the last busy-high cycle.
- The bit counter is LEN_W wide; len = 2^LEN_W−1 is legal.
- All outputs are registered.

## Configuration
- SPI_LOOPBACK_EN defined:
  - Adds input port lpbk (1 bit).
  - lpbk=1 feeds the internal mosi into the receive path in place of miso, and holds all cs_n high.
- SPI_LOOPBACK_EN undefined: port absent; receive always samples miso.

## Test plan
- Write, mode 0:
  - Stimulus: op=1, div=0, len=16, cs_sel=0, tx_data 0x67 then 0xAA after tx_next.
  - mosi sequence: 01100111 10101010.
  - tx_next pulses 2×; rx_valid never asserts.
  - busy lasts 35 cycles; done pulses once.
- Full duplex, mode 0:
  - Stimulus: op=0, len=48, div=1, miso toggling every sampled bit starting at 0.
  - Six rx_valid pulses, each with rx_data=0x55.
  - busy lasts 198 cycles.
- Mode 3 loopback (SPI_LOOPBACK_EN):
  - Stimulus: lpbk=1, op=0, cpol=1, cpha=1, len=8, tx_data=0xA5.
  - rx_data=0xA5; sck idles high; cs_n stays all 1.
- Partial word:
  - Stimulus: op=0, len=12, miso constant 1.
  - rx_valid pulses twice: 0xFF, then 0x0F.
  - tx_next pulses twice.
- Reset mid-transfer and guard cases:
  - rst asserted during SHIFT: cs_n=all 1, sck=0, busy=0 within the same cycle; no done.
  - work during busy is ignored.
  - len=0 produces no busy.
